// File: rtl/ddr_arbiter.sv
// Round-robin arbiter that moves 128-bit bursts between the camera write FIFO,
// the memory controller native port and the display read FIFO.
module ddr_arbiter #(
    parameter int BURST_LEN = 16,
    parameter int ADDR_STEP = 8,
    parameter int FRAME_END = 2073600
) (
    input  logic         sclk,
    input  logic         s_rst,
    input  logic         init_done,
    input  logic         wr_trig,
    input  logic         rd_trig,
    input  logic         cam_vs,
    input  logic         hdmi_vs,
    output logic         wfifo_rd_en,
    input  logic [127:0] wfifo_rd_data,
    output logic         rfifo_wr_en,
    output logic [127:0] rfifo_wr_data,
    output logic         mem_cmd_en,
    output logic [2:0]   mem_cmd_instr,
    output logic [27:0]  mem_cmd_addr,
    input  logic         mem_cmd_rdy,
    output logic         mem_wdf_wren,
    output logic [127:0] mem_wdf_data,
    input  logic         mem_wdf_rdy,
    input  logic         mem_rd_valid,
    input  logic [127:0] mem_rd_data
);

    localparam int               CNT_W       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(BURST_LEN - 1);
    localparam logic [27:0]      BURST_SPAN  = 28'(BURST_LEN * ADDR_STEP);
    localparam logic [27:0]      ADDR_END    = 28'(FRAME_END);

    localparam logic [4:0] IDLE    = 5'b00001;
    localparam logic [4:0] WR_CMD  = 5'b00010;
    localparam logic [4:0] WR_DATA = 5'b00100;
    localparam logic [4:0] RD_CMD  = 5'b01000;
    localparam logic [4:0] RD_WAIT = 5'b10000;

    logic [4:0]       state;
    logic [CNT_W-1:0] beat_cnt;
    logic [27:0]      wr_addr, rd_addr;
    logic [27:0]      wr_addr_nxt, rd_addr_nxt;
    logic             last_wr;
    logic             pend_wr_rst, pend_rd_rst;
    logic             cam_vs_d, hdmi_vs_d;
    logic             cam_rise, hdmi_rise;
    logic             wr_beat, rd_beat, wr_done, rd_done;
    logic             in_idle;

    assign cam_rise  = cam_vs & ~cam_vs_d;
    assign hdmi_rise = hdmi_vs & ~hdmi_vs_d;
    assign in_idle   = (state == IDLE);

    // Beat acceptance is masked by reset so an aborted burst pops nothing more.
    assign wr_beat = (state == WR_DATA) && mem_wdf_rdy && !s_rst;
    assign rd_beat = (state == RD_WAIT) && mem_rd_valid;
    assign wr_done = wr_beat && (beat_cnt == LAST_BEAT);
    assign rd_done = rd_beat && (beat_cnt == LAST_BEAT);

    assign wr_addr_nxt = (wr_addr + BURST_SPAN == ADDR_END) ? 28'd0 : wr_addr + BURST_SPAN;
    assign rd_addr_nxt = (rd_addr + BURST_SPAN == ADDR_END) ? 28'd0 : rd_addr + BURST_SPAN;

    assign mem_cmd_en    = !s_rst && ((state == WR_CMD) || (state == RD_CMD));
    assign mem_cmd_instr = (state == RD_CMD) ? 3'b001 : 3'b000;
    assign mem_cmd_addr  = (state == WR_CMD) ? wr_addr :
                           (state == RD_CMD) ? rd_addr : 28'd0;
    assign wfifo_rd_en   = wr_beat;
    assign mem_wdf_wren  = wr_beat;
    assign mem_wdf_data  = (state == WR_DATA) ? wfifo_rd_data : 128'd0;
    assign rfifo_wr_en   = mem_rd_valid;
    assign rfifo_wr_data = mem_rd_data;

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            wr_addr     <= '0;
            rd_addr     <= '0;
            last_wr     <= 1'b0;
            pend_wr_rst <= 1'b0;
            pend_rd_rst <= 1'b0;
            cam_vs_d    <= 1'b0;
            hdmi_vs_d   <= 1'b0;
        end else begin
            cam_vs_d  <= cam_vs;
            hdmi_vs_d <= hdmi_vs;

            // Frame restarts are only applied between bursts; zero wins over advance.
            if (in_idle && (pend_wr_rst || cam_rise)) begin
                wr_addr     <= '0;
                pend_wr_rst <= 1'b0;
            end else begin
                if (cam_rise) pend_wr_rst <= 1'b1;
                if (wr_done)  wr_addr     <= wr_addr_nxt;
            end

            if (in_idle && (pend_rd_rst || hdmi_rise)) begin
                rd_addr     <= '0;
                pend_rd_rst <= 1'b0;
            end else begin
                if (hdmi_rise) pend_rd_rst <= 1'b1;
                if (rd_done)   rd_addr     <= rd_addr_nxt;
            end

            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (init_done) begin
                        if (wr_trig && (!rd_trig || !last_wr)) begin
                            state   <= WR_CMD;
                            last_wr <= 1'b1;
                        end else if (rd_trig) begin
                            state   <= RD_CMD;
                            last_wr <= 1'b0;
                        end
                    end
                end
                WR_CMD:  if (mem_cmd_rdy) state <= WR_DATA;
                WR_DATA: begin
                    if (wr_beat) beat_cnt <= beat_cnt + 1'b1;
                    if (wr_done) state    <= IDLE;
                end
                RD_CMD:  if (mem_cmd_rdy) state <= RD_WAIT;
                RD_WAIT: begin
                    if (rd_beat) beat_cnt <= beat_cnt + 1'b1;
                    if (rd_done) state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ddr_arbiter.md
DDR_ARBITER -- requirements
Module: ddr_arbiter

Interface
REQ-001 The module SHALL provide parameter BURST_LEN, default 16, meaning 128-bit beats per burst.
REQ-002 The module SHALL provide parameter ADDR_STEP, default 8, meaning address units per beat.
REQ-003 The module SHALL provide parameter FRAME_END, default 2073600, meaning the exclusive frame address limit, a multiple of BURST_LEN*ADDR_STEP.
REQ-004 sclk, input, 1: the single clock; every port is synchronous to sclk.
REQ-005 s_rst, input, 1: synchronous, active-high reset.
REQ-006 init_done, input, 1: memory calibration complete.
REQ-007 wr_trig, input, 1: write FIFO holds at least one burst.
REQ-008 rd_trig, input, 1: read FIFO has room for at least one burst.
REQ-009 cam_vs, input, 1: camera frame sync, level; write frame restarts on its rising edge.
REQ-010 hdmi_vs, input, 1: display frame sync, level; read frame restarts on its rising edge.
REQ-011 wfifo_rd_en, output, 1: write FIFO pop; the FIFO is first-word-fall-through.
REQ-012 wfifo_rd_data, input, 128: write FIFO head data.
REQ-013 rfifo_wr_en, output, 1: read FIFO push.
REQ-014 rfifo_wr_data, output, 128: read FIFO push data.
REQ-015 mem_cmd_en, output, 1: command valid.
REQ-016 mem_cmd_instr, output, 3: command opcode; 3'b000 = write, 3'b001 = read.
REQ-017 mem_cmd_addr, output, 28: command start address.
REQ-018 mem_cmd_rdy, input, 1: command accepted when high together with mem_cmd_en.
REQ-019 mem_wdf_wren, output, 1: write data valid.
REQ-020 mem_wdf_data, output, 128: write data.
REQ-021 mem_wdf_rdy, input, 1: write data accepted when high together with mem_wdf_wren.
REQ-022 mem_rd_valid, input, 1: read data beat valid.
REQ-023 mem_rd_data, input, 128: read data.

Function
REQ-024 The FSM SHALL have the states IDLE, WR_CMD, WR_DATA, RD_CMD and RD_WAIT, encoded one-hot.
REQ-025 In IDLE with init_done=0, no request SHALL be granted.
REQ-026 In IDLE with init_done=1, the FSM SHALL go to WR_CMD if only wr_trig is high, and to RD_CMD if only rd_trig is high.
REQ-027 In IDLE with both wr_trig and rd_trig high, the grant SHALL go to the type not served last (round-robin); the last_wr flag SHALL reset to 0, so the first tie grants write.
REQ-028 In WR_CMD and RD_CMD, mem_cmd_en SHALL be 1 and mem_cmd_addr/mem_cmd_instr SHALL hold stable until mem_cmd_rdy; on acceptance the FSM SHALL move to WR_DATA or RD_WAIT respectively.
REQ-029 In WR_DATA, wfifo_rd_en and mem_wdf_wren SHALL both equal mem_wdf_rdy (combinational, same cycle), and mem_wdf_data SHALL equal wfifo_rd_data.
REQ-030 In WR_DATA, a beat counter SHALL count accepted beats; after beat BURST_LEN-1 the FSM SHALL return to IDLE, with exactly BURST_LEN pops per burst.
REQ-031 rfifo_wr_en SHALL equal mem_rd_valid and rfifo_wr_data SHALL equal mem_rd_data, combinationally in every state.
REQ-032 In RD_WAIT, the FSM SHALL count mem_rd_valid beats and return to IDLE after BURST_LEN beats.
REQ-033 On burst completion, the active address SHALL advance by BURST_LEN*ADDR_STEP; when the next address equals FRAME_END it SHALL wrap to 0.
REQ-034 wr_addr and rd_addr SHALL be independent 28-bit registers.
REQ-035 Rising edges of cam_vs and hdmi_vs SHALL be detected with one register each.
REQ-036 A cam_vs edge SHALL set pend_wr_rst; a hdmi_vs edge SHALL set pend_rd_rst.
REQ-037 A pending flag SHALL zero its address, and then clear, only in IDLE, so a burst in flight always completes at its issued address.
REQ-038 A frame-sync edge coinciding with a burst-completion increment SHALL still zero the address, with zero taking priority.
REQ-039 A single grant decision SHALL be made per IDLE cycle, giving a minimum of 1 IDLE cycle between bursts.
REQ-040 Triggers deasserting mid-burst SHALL be ignored; the burst always completes.

Reset
REQ-041 While s_rst=1 at a clock edge, the FSM SHALL go to IDLE and wr_addr, rd_addr, the beat counter, last_wr, the pending flags and the edge registers SHALL clear to 0.
REQ-042 Reset asserted mid-burst SHALL abort the burst immediately; no beat completion is owed.
REQ-043 During and after reset, mem_cmd_en, mem_wdf_wren and wfifo_rd_en SHALL be 0.

Verification
REQ-044 With init_done=1, wr_trig=1, rd_trig=0 and mem_cmd_rdy/mem_wdf_rdy tied high, the bench SHALL see one write command at addr 0, 16 pops in consecutive cycles, and the next command at addr 128.
REQ-045 With wr_trig=rd_trig=1 held, the bench SHALL see commands alternating write, read, write, read with addresses 0, 0, 128, 128.
REQ-046 With mem_wdf_rdy toggling 1-0-1-0, the bench SHALL see 16 pops exactly on the rdy-high cycles and the burst ending after the 16th accepted beat.
REQ-047 With rd_addr=FRAME_END-128, completing a read burst SHALL wrap rd_addr to 0.
REQ-048 A hdmi_vs rising edge during RD_WAIT SHALL let the current burst finish at its address, and the next read SHALL be issued at address 0.
REQ-049 Asserting s_rst during WR_DATA beat 5 SHALL give an IDLE FSM and all outputs 0 on the next cycle; with init_done=0 and both triggers high, no mem_cmd_en SHALL assert.
